ex_div: RTL and testbench
=========================

Name: ex_div

Overview:
- Execute stage of the SammingCPU 5-stage pipeline.
- Consumes the operation registered by the ID/EX pipeline register: aluop, alusel, operands, write address and write enable. Produces the write-back result for EX/MEM and HI/LO update requests.
- Logic, shift, arithmetic and move ops resolve in one cycle.
- DIV/DIVU run on an internal 32-iteration restoring divider. While it runs, stallreq_o is raised so the controller freezes PC..ID/EX.

Parameters:
- DIV_CYCLES, 32, number of ON-state iterations; must equal the operand width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- aluop_i  in  8  operation code
- alusel_i  in  3  result-class select
- reg1_i  in  32  operand 1 (rs / dividend)
- reg2_i  in  32  operand 2 (rt / divisor / shift source)
- wd_i  in  5  destination register address
- wreg_i  in  1  destination write enable
- hi_i  in  32  current HI, already forwarded from MEM/WB
- lo_i  in  32  current LO, already forwarded from MEM/WB
- wd_o  out  5  destination address to EX/MEM
- wreg_o  out  1  write enable to EX/MEM
- wdata_o  out  32  result to EX/MEM
- whilo_o  out  1  HI/LO write enable
- hi_o  out  32  HI write data
- lo_o  out  32  LO write data
- stallreq_o  out  1  pipeline stall request to ctrl

Behaviour:
- Encodings, aluop:
  - NOP 0x00, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27
  - SLL 0x7C, SRL 0x02, SRA 0x03
  - ADDU 0x21, SUBU 0x23, SLT 0x2A, SLTU 0x2B
  - MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13
  - DIV 0x1A, DIVU 0x1B
- Encodings, alusel: NOP 000, LOGIC 001, SHIFT 010, MOVE 011, ARITH 100.
- Single-cycle ops:
  - wdata_o is selected by alusel_i; an unknown alusel gives 0.
  - Shift amount is reg1_i[4:0] and the shifted value is reg2_i. SRA is arithmetic.
  - ADDU/SUBU wrap modulo 2^32 with no overflow trap.
  - SLT is a signed compare; SLTU is unsigned. Result is 32'h1 or 32'h0.
  - MFHI/MFLO return hi_i/lo_i.
- HI/LO writes:
  - MTHI: whilo_o=1, hi_o=reg1_i, lo_o=lo_i.
  - MTLO: whilo_o=1, hi_o=hi_i, lo_o=reg1_i.
  - All other non-divide ops: whilo_o=0, hi_o=0, lo_o=0.
- Pass-through: wd_o=wd_i and wreg_o=wreg_i, combinational.
- Divider FSM states: IDLE, BYZERO, ON, END. State, 6-bit counter, 65-bit dividend/remainder register and latched operands/sign flags all update on posedge clk.
  - IDLE:
    - If aluop is DIV/DIVU and reg2_i==0, go to BYZERO.
    - If aluop is DIV/DIVU and reg2_i!=0, go to ON. Latch operands, taking absolute values for DIV. Counter=0.
    - Otherwise stay in IDLE.
  - BYZERO: result={hi,lo}=0; go to END.
  - ON:
    - Each cycle performs one shift-subtract step and increments the counter.
    - After DIV_CYCLES steps, go to END. Final fix-up for DIV:
      - Negate the quotient if the operand signs differ.
      - Give the remainder the sign of the dividend.
  - END: result held; go to IDLE next edge unconditionally.
- stallreq_o:
  - High (combinational) in IDLE when the op is DIV/DIVU, and in BYZERO and ON.
  - Low in END.
- For DIV/DIVU, whilo_o=1, hi_o=remainder and lo_o=quotient only in END; otherwise 0.
- For DIV/DIVU, wreg_o follows wreg_i, which ID drives to 0.
- Latency: divide issued in cycle 0 → stallreq_o high in cycles 0..32, END in cycle 33, pipeline advances at the end of cycle 33. Divide by zero: END in cycle 2.
- Back-to-back divides: the second DIV is seen in IDLE on the cycle after END and restarts the FSM. The completed result is never re-issued.
- Reset: rst=1 forces IDLE, counter=0 and result=0.
  - While rst is high: wd_o=0, wreg_o=0, wdata_o=0, whilo_o=0, hi_o=0, lo_o=0, stallreq_o=0.
  - Reset mid-divide aborts the divide with no HI/LO write.
- Inputs change during ON or BYZERO are ignored; the latched operands are used.

Test Plan:
- OR, reg1=0x0F0F0000, reg2=0x0000F0F0, wd=5, wreg=1 → same cycle wdata_o=0x0F0FF0F0, wd_o=5, wreg_o=1, stallreq_o=0.
- SRA, reg1=4, reg2=0x80000000 → wdata_o=0xF8000000. SLT, reg1=0xFFFFFFFF, reg2=1 → 1. SLTU with the same operands → 0.
- DIVU, reg1=100, reg2=7 → stallreq_o high 33 cycles. END cycle: whilo_o=1, hi_o=2, lo_o=14.
- DIV, reg1=0xFFFFFF9C (-100), reg2=7 → END: lo_o=0xFFFFFFF2 (-14), hi_o=0xFFFFFFFE (-2).
- DIV, reg2=0 → stallreq_o high exactly 2 cycles, then hi_o=lo_o=0, whilo_o=1.
- DIVU started, rst asserted at iteration 10 → next cycle state IDLE, stallreq_o=0, whilo_o stays 0. After release, a new DIVU 9/3 yields lo_o=3, hi_o=0. MTHI reg1=0x1234 gives whilo_o=1, hi_o=0x1234, lo_o=lo_i.

Source files
------------

// File: rtl/ex_div_if.sv
// ex_div_if: ID/EX operation bundle into the execute stage and its
// EX/MEM result, HI/LO request and stall outputs.
interface ex_div_if;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        whilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        stallreq_o;

    modport master (
        output aluop_i, alusel_i, reg1_i, reg2_i,
        output wd_i, wreg_i, hi_i, lo_i,
        input  wd_o, wreg_o, wdata_o,
        input  whilo_o, hi_o, lo_o, stallreq_o
    );

    modport slave (
        input  aluop_i, alusel_i, reg1_i, reg2_i,
        input  wd_i, wreg_i, hi_i, lo_i,
        output wd_o, wreg_o, wdata_o,
        output whilo_o, hi_o, lo_o, stallreq_o
    );
endinterface

// File: rtl/ex_div.sv
// ex_div: execute stage with single-cycle ALU ops and a
// multi-cycle restoring divider that stalls the front of the pipe.
module ex_div #(
    parameter int DIV_CYCLES = 32
) (
    input logic   clk,
    input logic   rst,
    ex_div_if.slave bus
);
    localparam logic [7:0] OP_AND  = 8'h24;
    localparam logic [7:0] OP_OR   = 8'h25;
    localparam logic [7:0] OP_XOR  = 8'h26;
    localparam logic [7:0] OP_NOR  = 8'h27;
    localparam logic [7:0] OP_SLL  = 8'h7C;
    localparam logic [7:0] OP_SRL  = 8'h02;
    localparam logic [7:0] OP_SRA  = 8'h03;
    localparam logic [7:0] OP_ADDU = 8'h21;
    localparam logic [7:0] OP_SUBU = 8'h23;
    localparam logic [7:0] OP_SLT  = 8'h2A;
    localparam logic [7:0] OP_SLTU = 8'h2B;
    localparam logic [7:0] OP_MFHI = 8'h10;
    localparam logic [7:0] OP_MTHI = 8'h11;
    localparam logic [7:0] OP_MFLO = 8'h12;
    localparam logic [7:0] OP_MTLO = 8'h13;
    localparam logic [7:0] OP_DIV  = 8'h1A;
    localparam logic [7:0] OP_DIVU = 8'h1B;

    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_MOVE  = 3'b011;
    localparam logic [2:0] SEL_ARITH = 3'b100;

    localparam logic [5:0] LAST = 6'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BYZERO,
        S_ON,
        S_END
    } state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [64:0] rq;
    logic [31:0] dvsr;
    logic        neg_q;
    logic        neg_r;
    logic [63:0] res;

    logic        is_div;
    logic        is_sdiv;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [33:0] diff;
    logic [64:0] rq_nxt;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    assign is_div  = (bus.aluop_i == OP_DIV) || (bus.aluop_i == OP_DIVU);
    assign is_sdiv = (bus.aluop_i == OP_DIV);
    assign a_abs   = (is_sdiv && bus.reg1_i[31]) ? -bus.reg1_i : bus.reg1_i;
    assign b_abs   = (is_sdiv && bus.reg2_i[31]) ? -bus.reg2_i : bus.reg2_i;

    // Upper half holds the partial remainder, lower half collects
    // quotient bits as the dividend shifts out.
    assign diff   = rq[64:31] - {2'b00, dvsr};
    assign rq_nxt = diff[33] ? {rq[63:0], 1'b0}
                             : {diff[32:0], rq[30:0], 1'b1};
    assign q_fix  = neg_q ? -rq_nxt[31:0]  : rq_nxt[31:0];
    assign r_fix  = neg_r ? -rq_nxt[63:32] : rq_nxt[63:32];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            rq    <= '0;
            dvsr  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            res   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (is_div) begin
                        if (bus.reg2_i == 32'd0) begin
                            state <= S_BYZERO;
                        end else begin
                            state <= S_ON;
                            cnt   <= '0;
                            rq    <= {33'd0, a_abs};
                            dvsr  <= b_abs;
                            neg_q <= is_sdiv &&
                                     (bus.reg1_i[31] ^ bus.reg2_i[31]);
                            neg_r <= is_sdiv && bus.reg1_i[31];
                        end
                    end
                end
                S_BYZERO: begin
                    res   <= '0;
                    state <= S_END;
                end
                S_ON: begin
                    rq  <= rq_nxt;
                    cnt <= cnt + 6'd1;
                    if (cnt == LAST) begin
                        res   <= {r_fix, q_fix};
                        state <= S_END;
                    end
                end
                S_END: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [31:0] logic_res;
    logic [31:0] shift_res;
    logic [31:0] move_res;
    logic [31:0] arith_res;
    logic [31:0] wdata;
    logic [4:0]  sh;

    assign sh = bus.reg1_i[4:0];

    always_comb begin
        logic_res = '0;
        shift_res = '0;
        move_res  = '0;
        arith_res = '0;
        case (bus.aluop_i)
            OP_AND:  logic_res = bus.reg1_i & bus.reg2_i;
            OP_OR:   logic_res = bus.reg1_i | bus.reg2_i;
            OP_XOR:  logic_res = bus.reg1_i ^ bus.reg2_i;
            OP_NOR:  logic_res = ~(bus.reg1_i | bus.reg2_i);
            OP_SLL:  shift_res = bus.reg2_i << sh;
            OP_SRL:  shift_res = bus.reg2_i >> sh;
            OP_SRA:  shift_res = $signed(bus.reg2_i) >>> sh;
            OP_MFHI: move_res  = bus.hi_i;
            OP_MFLO: move_res  = bus.lo_i;
            OP_ADDU: arith_res = bus.reg1_i + bus.reg2_i;
            OP_SUBU: arith_res = bus.reg1_i - bus.reg2_i;
            OP_SLT:  arith_res = {31'd0,
                       $signed(bus.reg1_i) < $signed(bus.reg2_i)};
            OP_SLTU: arith_res = {31'd0, bus.reg1_i < bus.reg2_i};
            default: ;
        endcase
    end

    always_comb begin
        wdata = '0;
        unique case (1'b1)
            bus.alusel_i == SEL_LOGIC: wdata = logic_res;
            bus.alusel_i == SEL_SHIFT: wdata = shift_res;
            bus.alusel_i == SEL_MOVE:  wdata = move_res;
            bus.alusel_i == SEL_ARITH: wdata = arith_res;
            default: wdata = '0;
        endcase
    end

    always_comb begin
        bus.wd_o       = '0;
        bus.wreg_o     = 1'b0;
        bus.wdata_o    = '0;
        bus.whilo_o    = 1'b0;
        bus.hi_o       = '0;
        bus.lo_o       = '0;
        bus.stallreq_o = 1'b0;
        if (!rst) begin
            bus.wd_o       = bus.wd_i;
            bus.wreg_o     = bus.wreg_i;
            bus.wdata_o    = wdata;
            bus.stallreq_o = (state == S_IDLE && is_div) ||
                             state == S_BYZERO || state == S_ON;
            if (state == S_END) begin
                bus.whilo_o = 1'b1;
                bus.hi_o    = res[63:32];
                bus.lo_o    = res[31:0];
            end else if (bus.aluop_i == OP_MTHI) begin
                bus.whilo_o = 1'b1;
                bus.hi_o    = bus.reg1_i;
                bus.lo_o    = bus.lo_i;
            end else if (bus.aluop_i == OP_MTLO) begin
                bus.whilo_o = 1'b1;
                bus.hi_o    = bus.hi_i;
                bus.lo_o    = bus.reg1_i;
            end
        end
    end
endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: directed vectors for the execute stage ALU ops,
// HI/LO moves and the multi-cycle divider.
`timescale 1ns/1ps
module tb_ex_div;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    ex_div_if bus ();

    ex_div #(.DIV_CYCLES(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] r1, input logic [31:0] r2);
        @(posedge clk);
        #1;
        bus.aluop_i  = op;
        bus.alusel_i = sel;
        bus.reg1_i   = r1;
        bus.reg2_i   = r2;
    endtask

    task automatic wait_div(input string tag, input int exp_n);
        int n = 0;
        @(negedge clk);
        while (bus.stallreq_o && n < 60) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_stall"}, 64'(n), 64'(exp_n));
    endtask

    initial begin
        bus.aluop_i  = 8'h25;
        bus.alusel_i = 3'b001;
        bus.reg1_i   = 32'h1;
        bus.reg2_i   = 32'h2;
        bus.wd_i     = 5'd7;
        bus.wreg_i   = 1'b1;
        bus.hi_i     = 32'hAAAA;
        bus.lo_i     = 32'h5555;

        @(negedge clk);
        check("rst_wd", 64'(bus.wd_o), 64'd0);
        check("rst_wreg", 64'(bus.wreg_o), 64'd0);
        check("rst_wdata", 64'(bus.wdata_o), 64'd0);
        check("rst_stall", 64'(bus.stallreq_o), 64'd0);

        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.wd_i = 5'd5;
        drive(8'h25, 3'b001, 32'h0F0F0000, 32'h0000F0F0);
        @(negedge clk);
        check("or", 64'(bus.wdata_o), 64'h0F0FF0F0);
        check("or_wd", 64'(bus.wd_o), 64'd5);
        check("or_wreg", 64'(bus.wreg_o), 64'd1);
        check("or_stall", 64'(bus.stallreq_o), 64'd0);
        check("or_whilo", 64'(bus.whilo_o), 64'd0);

        drive(8'h03, 3'b010, 32'd4, 32'h80000000);
        @(negedge clk);
        check("sra", 64'(bus.wdata_o), 64'hF8000000);
        drive(8'h02, 3'b010, 32'd4, 32'h80000000);
        @(negedge clk);
        check("srl", 64'(bus.wdata_o), 64'h08000000);
        drive(8'h7C, 3'b010, 32'd8, 32'h1);
        @(negedge clk);
        check("sll", 64'(bus.wdata_o), 64'h100);
        drive(8'h2A, 3'b100, 32'hFFFFFFFF, 32'h1);
        @(negedge clk);
        check("slt", 64'(bus.wdata_o), 64'h1);
        drive(8'h2B, 3'b100, 32'hFFFFFFFF, 32'h1);
        @(negedge clk);
        check("sltu", 64'(bus.wdata_o), 64'h0);
        drive(8'h21, 3'b100, 32'hFFFFFFFF, 32'h2);
        @(negedge clk);
        check("addu", 64'(bus.wdata_o), 64'h1);
        drive(8'h23, 3'b100, 32'h0, 32'h1);
        @(negedge clk);
        check("subu", 64'(bus.wdata_o), 64'hFFFFFFFF);
        drive(8'h26, 3'b001, 32'hFF00FF00, 32'h0FF00FF0);
        @(negedge clk);
        check("xor", 64'(bus.wdata_o), 64'hF0F0F0F0);
        drive(8'h27, 3'b001, 32'h0, 32'h0);
        @(negedge clk);
        check("nor", 64'(bus.wdata_o), 64'hFFFFFFFF);
        drive(8'h10, 3'b011, 32'h0, 32'h0);
        @(negedge clk);
        check("mfhi", 64'(bus.wdata_o), 64'hAAAA);
        drive(8'h25, 3'b111, 32'h1, 32'h2);
        @(negedge clk);
        check("badsel", 64'(bus.wdata_o), 64'h0);

        bus.wreg_i = 1'b0;
        drive(8'h1B, 3'b000, 32'd100, 32'd7);
        wait_div("divu", 33);
        check("divu_whilo", 64'(bus.whilo_o), 64'd1);
        check("divu_hi", 64'(bus.hi_o), 64'd2);
        check("divu_lo", 64'(bus.lo_o), 64'd14);
        check("divu_wreg", 64'(bus.wreg_o), 64'd0);

        drive(8'h1A, 3'b000, 32'hFFFFFF9C, 32'd7);
        wait_div("div", 33);
        check("div_whilo", 64'(bus.whilo_o), 64'd1);
        check("div_hi", 64'(bus.hi_o), 64'hFFFFFFFE);
        check("div_lo", 64'(bus.lo_o), 64'hFFFFFFF2);

        drive(8'h1A, 3'b000, 32'd55, 32'd0);
        wait_div("div0", 2);
        check("div0_whilo", 64'(bus.whilo_o), 64'd1);
        check("div0_hi", 64'(bus.hi_o), 64'd0);
        check("div0_lo", 64'(bus.lo_o), 64'd0);

        drive(8'h00, 3'b000, 32'd0, 32'd0);
        @(negedge clk);
        check("idle_whilo", 64'(bus.whilo_o), 64'd0);

        drive(8'h1B, 3'b000, 32'd1000, 32'd3);
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("abort_stall", 64'(bus.stallreq_o), 64'd0);
        check("abort_whilo", 64'(bus.whilo_o), 64'd0);
        drive(8'h00, 3'b000, 32'd0, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_idle", 64'(bus.stallreq_o), 64'd0);
        check("abort_nowr", 64'(bus.whilo_o), 64'd0);

        drive(8'h1B, 3'b000, 32'd9, 32'd3);
        wait_div("divu93", 33);
        check("divu93_lo", 64'(bus.lo_o), 64'd3);
        check("divu93_hi", 64'(bus.hi_o), 64'd0);

        drive(8'h11, 3'b000, 32'h1234, 32'h0);
        @(negedge clk);
        check("mthi_whilo", 64'(bus.whilo_o), 64'd1);
        check("mthi_hi", 64'(bus.hi_o), 64'h1234);
        check("mthi_lo", 64'(bus.lo_o), 64'h5555);
        drive(8'h13, 3'b000, 32'h4321, 32'h0);
        @(negedge clk);
        check("mtlo_hi", 64'(bus.hi_o), 64'hAAAA);
        check("mtlo_lo", 64'(bus.lo_o), 64'h4321);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end
endmodule
